// File: rtl/display_scheduler.sv
// Round-robin scheduler that shows one of three 7-bit values on a two-digit
// display for DWELL cycles per grant, with saturation, hold and abort handling.
module display_scheduler #(
  parameter int unsigned DWELL = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [6:0] val0,
  input  logic [6:0] val1,
  input  logic [6:0] val2,
  input  logic       hold,
  output logic [6:0] wholeNum,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       blank,
  output logic       ovf
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [6:0] MAX_SHOWN = 7'd99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2,
    NEXT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       num_q, num_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       done_q, done_d;
  logic             blank_q, blank_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       val_sel;

  // Search order last+1, last+2, last (mod 3); lone requester wins again.
  function automatic logic [1:0] rr_pick(input logic [1:0] lst, input logic [2:0] r);
    logic [1:0] c0, c1;
    c0 = (lst >= 2'd2) ? 2'd0 : lst + 2'd1;
    c1 = (c0 >= 2'd2) ? 2'd0 : c0 + 2'd1;
    if (r[c0])      rr_pick = c0;
    else if (r[c1]) rr_pick = c1;
    else            rr_pick = lst;
  endfunction

  always_comb begin
    case (sel_q)
      2'd1:    val_sel = val1;
      2'd2:    val_sel = val2;
      default: val_sel = val0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    grant_d = grant_q;
    done_d  = 3'b000;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = rr_pick(last_q, req);
          state_d = LOAD;
        end
      end
      LOAD: begin
        num_d   = (val_sel > MAX_SHOWN) ? MAX_SHOWN : val_sel;
        ovf_d   = (val_sel > MAX_SHOWN);
        grant_d = 3'b001 << sel_q;
        blank_d = 1'b0;
        cnt_d   = '0;
        state_d = SHOW;
      end
      SHOW: begin
        // Abort outranks hold; hold outranks dwell completion.
        if (!req[sel_q]) begin
          last_d  = sel_q;
          state_d = NEXT;
        end else if (hold) begin
          cnt_d = cnt_q;
        end else if (cnt_q == CNT_LAST) begin
          done_d  = 3'b001 << sel_q;
          last_d  = sel_q;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NEXT: begin
        if (|req) begin
          sel_d   = rr_pick(last_q, req);
          state_d = LOAD;
        end else begin
          num_d   = 7'd0;
          grant_d = 3'b000;
          ovf_d   = 1'b0;
          blank_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      num_q   <= 7'd0;
      grant_q <= 3'b000;
      done_q  <= 3'b000;
      blank_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wholeNum = num_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign blank    = blank_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed scenarios plus randomized traffic, every cycle compared against a
// transaction-level model of the display scheduler.
module tb_display_scheduler;

  localparam int unsigned DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [6:0] val0 = 7'd0, val1 = 7'd0, val2 = 7'd0;
  logic       hold = 1'b0;
  logic [6:0] wholeNum;
  logic [2:0] grant, done;
  logic       blank, ovf;

  int checks = 0;
  int errors = 0;

  display_scheduler #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1), .val2(val2),
    .hold(hold), .wholeNum(wholeNum), .grant(grant), .done(done),
    .blank(blank), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: waiting / pending load / on screen / handing over.
  bit         m_waiting, m_pending, m_on_screen, m_handover;
  int         m_src, m_last, m_left;
  logic [6:0] e_num;
  logic [2:0] e_grant, e_done;
  logic       e_blank, e_ovf;

  function automatic int pick(input int lst, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (lst + k) % 3;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_edge();
    int v;
    e_done = 3'b000;
    if (rst) begin
      m_waiting = 1; m_pending = 0; m_on_screen = 0; m_handover = 0;
      m_src = 0; m_last = 2; m_left = 0;
      e_num = 7'd0; e_grant = 3'b000; e_blank = 1'b1; e_ovf = 1'b0;
      return;
    end
    if (m_waiting) begin
      if (req != 3'b000) begin
        m_src = pick(m_last, req); m_waiting = 0; m_pending = 1;
      end
    end else if (m_pending) begin
      v = (m_src == 0) ? int'(val0) : (m_src == 1) ? int'(val1) : int'(val2);
      e_num   = 7'((v > 99) ? 99 : v);
      e_ovf   = (v > 99);
      e_grant = 3'(1 << m_src);
      e_blank = 1'b0;
      m_left  = DWELL;
      m_pending = 0; m_on_screen = 1;
    end else if (m_on_screen) begin
      if (!req[m_src]) begin
        m_last = m_src; m_on_screen = 0; m_handover = 1;
      end else if (!hold) begin
        m_left--;
        if (m_left == 0) begin
          e_done = 3'(1 << m_src);
          m_last = m_src; m_on_screen = 0; m_handover = 1;
        end
      end
    end else if (m_handover) begin
      m_handover = 0;
      if (req != 3'b000) begin
        m_src = pick(m_last, req); m_pending = 1;
      end else begin
        m_waiting = 1;
        e_num = 7'd0; e_grant = 3'b000; e_ovf = 1'b0; e_blank = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant",    32'(grant),    32'(e_grant));
    chk("wholeNum", 32'(wholeNum), 32'(e_num));
    chk("done",     32'(done),     32'(e_done));
    chk("blank",    32'(blank),    32'(e_blank));
    chk("ovf",      32'(ovf),      32'(e_ovf));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 3'b000; hold = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int dones;
    logic [2:0] seen_done;
    logic [2:0] prev;
    logic [2:0] gq[$];
    logic [2:0] rr_exp[4];

    // Reset state
    do_reset();
    chk("reset_blank", 32'(blank), 32'd1);
    chk("reset_grant", 32'(grant), 32'd0);

    // Single source: grant two cycles after req, done after DWELL show cycles
    req = 3'b001; val0 = 7'd42;
    step(); step();
    chk("single_grant", 32'(grant), 32'd1);
    chk("single_num",   32'(wholeNum), 32'd42);
    chk("single_blank", 32'(blank), 32'd0);
    n = 0;
    while (done == 3'b000 && n < 20) begin step(); n++; end
    chk("single_done", 32'(done), 32'd1);
    chk("single_dwell", 32'(n), 32'(DWELL));
    step(); step();
    chk("single_regrant", 32'(grant), 32'd1);
    chk("single_regrant_done", 32'(done), 32'd0);

    // Round-robin order with one done per completed dwell
    do_reset();
    req = 3'b111; val0 = 7'd5; val1 = 7'd17; val2 = 7'd88;
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    prev = 3'b000; dones = 0; n = 0;
    gq.delete();
    while (gq.size() < 4 && n < 100) begin
      step(); n++;
      if (done != 3'b000 && gq.size() > 0) dones++;
      if (grant != prev && grant != 3'b000) gq.push_back(grant);
      prev = grant;
    end
    chk("rr_count", 32'(gq.size()), 32'd4);
    foreach (gq[i]) chk("rr_order", 32'(gq[i]), 32'(rr_exp[i]));
    chk("rr_dones", 32'(dones), 32'd3);

    // Saturation; value changes during SHOW are ignored
    do_reset();
    req = 3'b010; val1 = 7'd127;
    step(); step();
    chk("sat_num", 32'(wholeNum), 32'd99);
    chk("sat_ovf", 32'(ovf), 32'd1);
    val1 = 7'd120;
    step(); step();
    chk("sat_hold_num", 32'(wholeNum), 32'd99);

    // Abort mid-SHOW: no done, then blank
    do_reset();
    req = 3'b100; val2 = 7'd33;
    step(); step(); step();
    req = 3'b000;
    seen_done = 3'b000;
    step(); seen_done |= done;
    step(); seen_done |= done;
    chk("abort_done",  32'(seen_done), 32'd0);
    chk("abort_blank", 32'(blank), 32'd1);
    chk("abort_num",   32'(wholeNum), 32'd0);
    chk("abort_grant", 32'(grant), 32'd0);

    // Hold for 3 cycles delays done by 3
    do_reset();
    req = 3'b001; val0 = 7'd9;
    step(); step();
    step(); n = 1;
    hold = 1'b1;
    step(); step(); step(); n += 3;
    hold = 1'b0;
    while (done == 3'b000 && n < 30) begin step(); n++; end
    chk("hold_done",  32'(done), 32'd1);
    chk("hold_dwell", 32'(n), 32'(DWELL + 3));

    // Reset during SHOW abandons grant; restart grants source 0 first
    do_reset();
    req = 3'b111;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    rst = 1'b0;
    step(); step();
    chk("rst_first_grant", 32'(grant), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) val0 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) val1 = 7'($urandom);
      if ($urandom_range(0, 3) == 0) val2 = 7'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
